mem_arbiter_ctrl: RTL
=====================

// Module: mem_arbiter_ctrl
// PURPOSE
//  Shares the single-port 8x8 RAM between two requesters (port A, port B).
//  Round-robin arbitration, valid/ready request handshake, one-cycle response pulse for reads.
//  Also sequences a whole-array clear through the RAM's synchronous clear input.
//  Sits between the RAM and its two client blocks; owns every RAM control pin.
// PARAMETERS
//  ADDR_WIDTH  3  RAM address width (depth = 2**ADDR_WIDTH)
//  DATA_WIDTH  8  RAM data width
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  a_valid      in   1           port A request valid
//  a_we         in   1           port A request: 1 = write, 0 = read
//  a_addr       in   ADDR_WIDTH  port A address
//  a_wdata      in   DATA_WIDTH  port A write data
//  a_ready      out  1           port A request accepted this cycle
//  a_rsp_valid  out  1           port A read data valid, one-cycle pulse
//  a_rsp_rdata  out  DATA_WIDTH  port A read data
//  b_*          (same 7 signals for port B)
//  clr_start    in   1           request a full RAM clear
//  clr_done     out  1           one-cycle pulse: clear completed
//  busy         out  1           controller not in IDLE
//  mem_rst      out  1           to RAM rst (sync, active-high)
//  mem_we       out  1           to RAM we
//  mem_addr     out  ADDR_WIDTH  to RAM addr
//  mem_wrdata   out  DATA_WIDTH  to RAM wrdata
//  mem_rddata   in   DATA_WIDTH  from RAM rddata (registered; updates when mem_we=0, mem_rst=0)
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, rr pointer = A.
//   All outputs 0 except mem_rst = 1, so the RAM clears while clk runs.
//   mem_rst drops to 0 on the first edge after rst_n deasserts.
//  States: IDLE, ISSUE, RESP, CLEAR.
//  IDLE:
//   - clr_start=1 has priority over all requests: no ready asserted; next state CLEAR.
//   - else if any *_valid: grant one port; its *_ready = 1 combinationally (handshake this cycle).
//     Granted addr/we/wdata are registered into mem_*; next state ISSUE.
//   - Arbitration: only one port valid -> that port. Both valid -> port at rr pointer.
//   - The rr pointer moves to the non-granted port after every grant.
//  ISSUE: mem_addr/mem_wrdata hold the latched values; mem_we = latched we for this cycle only.
//   - Write: RAM writes at the ISSUE edge; next state IDLE. No response pulse for writes.
//   - Read: mem_we=0, so the RAM latches rddata at this edge; next state RESP.
//  RESP: mem_we=0, address held.
//   - Granted port's *_rsp_valid = 1 for exactly one cycle, *_rsp_rdata = mem_rddata.
//   - Non-granted port: rsp_rdata holds its previous value.
//   - Next state IDLE. No response backpressure.
//  CLEAR: mem_rst = 1 for one cycle, mem_we = 0; next state IDLE; clr_done = 1 in that IDLE cycle.
//  Timing (acceptance = cycle T):
//   - write: mem_we high in T+1.
//   - read: rsp_valid in T+2.
//   - Next acceptance earliest at T+2 after a write, T+3 after a read.
//  *_ready is 0 outside IDLE. Unaccepted requests must hold valid and payload stable.
//  busy = (state != IDLE).
//  mem_we is 0 in every state except ISSUE-write, so the RAM never sees a write outside a granted slot.
//  Reset mid-operation: any in-flight request is dropped with no response; the requester re-issues.
//  Address wrap does not apply: the address is passed through unmodified and is always in range.
// TESTING
//  1. Reset release -> all outputs 0, mem_rst=1 until the first edge after release.
//     Then A reads addr 5 -> a_rsp_rdata=8'h00 at T+2.
//  2. A writes 8'hA5 @3; later A reads @3 -> a_ready at T, mem_we=1 in T+1 only, a_rsp_valid at T+2 with 8'hA5.
//  3. A and B both valid reads from reset (@1 and @2, holding 8'h11 and 8'h22):
//     A is granted first, then B; B's response has B's data; the rr pointer ends at A.
//  4. clr_start together with a_valid in IDLE -> CLEAR first, clr_done one cycle later.
//     Then A is granted; a read of a previously written address returns 8'h00.
//  5. rst_n asserted during RESP -> no rsp_valid; busy=0 and mem_rst=1 immediately (async).
//  6. Back-to-back A writes, B idle -> a_ready every 2 cycles; no write is lost.

Source files
------------

// File: rtl/mem_arbiter_ctrl_if.sv
// Bus bundle between mem_arbiter_ctrl, its two requesters, the clear control and the RAM.
// No latency of its own; it only groups wires.
// The slave modport is the controller side and the master modport is the client/RAM side.
interface mem_arbiter_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    // port A
    logic                  a_valid;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ready;
    logic                  a_rsp_valid;
    logic [DATA_WIDTH-1:0] a_rsp_rdata;
    // port B
    logic                  b_valid;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ready;
    logic                  b_rsp_valid;
    logic [DATA_WIDTH-1:0] b_rsp_rdata;
    // clear control / status
    logic                  clr_start;
    logic                  clr_done;
    logic                  busy;
    // RAM pins
    logic                  mem_rst;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wrdata;
    logic [DATA_WIDTH-1:0] mem_rddata;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rsp_valid, a_rsp_rdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rsp_valid, b_rsp_rdata,
        input  clr_start,
        output clr_done, busy,
        output mem_rst, mem_we, mem_addr, mem_wrdata,
        input  mem_rddata
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rsp_valid, a_rsp_rdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rsp_valid, b_rsp_rdata,
        output clr_start,
        input  clr_done, busy,
        input  mem_rst, mem_we, mem_addr, mem_wrdata,
        output mem_rddata
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between ports A and B, plus whole-array clear.
// Latency: write hits RAM one cycle after acceptance; read response pulses two cycles after acceptance.
// Backpressure: *_ready only in IDLE (clear wins); responses cannot be stalled.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the A/B request/response,
// clr_start/clr_done/busy and the RAM pins mem_rst/mem_we/mem_addr/mem_wrdata/mem_rddata.
module mem_arbiter_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_arbiter_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, CLEAR} state_t;

    state_t                state, state_nxt;
    logic                  accept;      // a request is handshaken this cycle
    logic                  sel_b;       // winner of this cycle's arbitration
    logic                  rr_b;        // 1: B wins a tie next time
    logic                  gnt_b;       // port owning the in-flight request
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;
    logic                  rst_hold;    // keeps the RAM in reset until the first edge after rst_n release
    logic                  clr_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_b       <= 1'b0;
            gnt_b      <= 1'b0;
            lat_we     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            rst_hold   <= 1'b1;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_hold   <= 1'b0;
            clr_done_q <= (state == CLEAR);
            if (accept) begin
                gnt_b   <= sel_b;
                rr_b    <= ~sel_b;
                lat_we  <= sel_b ? bus.b_we    : bus.a_we;
                addr_q  <= sel_b ? bus.b_addr  : bus.a_addr;
                wdata_q <= sel_b ? bus.b_wdata : bus.a_wdata;
            end
            // Capture the response so the port keeps showing it after the pulse.
            if (state == RESP) begin
                if (gnt_b) b_rdata_q <= bus.mem_rddata;
                else       a_rdata_q <= bus.mem_rddata;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        sel_b           = 1'b0;
        bus.a_ready     = 1'b0;
        bus.b_ready     = 1'b0;
        bus.a_rsp_valid = 1'b0;
        bus.b_rsp_valid = 1'b0;
        bus.a_rsp_rdata = a_rdata_q;
        bus.b_rsp_rdata = b_rdata_q;
        bus.clr_done    = clr_done_q;
        bus.busy        = (state != IDLE);
        bus.mem_rst     = rst_hold;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = addr_q;
        bus.mem_wrdata  = wdata_q;

        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_nxt = CLEAR;
                end else if (bus.a_valid || bus.b_valid) begin
                    accept      = 1'b1;
                    sel_b       = bus.b_valid && (!bus.a_valid || rr_b);
                    bus.a_ready = ~sel_b;
                    bus.b_ready = sel_b;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_we = lat_we;
                state_nxt  = lat_we ? IDLE : RESP;
            end
            RESP: begin
                if (gnt_b) begin
                    bus.b_rsp_valid = 1'b1;
                    bus.b_rsp_rdata = bus.mem_rddata;
                end else begin
                    bus.a_rsp_valid = 1'b1;
                    bus.a_rsp_rdata = bus.mem_rddata;
                end
                state_nxt = IDLE;
            end
            CLEAR: begin
                bus.mem_rst = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
